fifo_rptr_empty: RTL and testbench

Read-side pointer and empty-flag controller for the async FIFO. It is the counterpart of the write-side pointer/full logic.
- Synchronises the write domain's Gray write pointer into rclk.
- Keeps the binary and Gray read pointers and drives the RAM read address.
- Produces the registered empty, almost-empty, occupancy and underflow status.
- Uses the pkg_graybin b2g/g2b conversions; DEPTH and ADDRSIZE match the write side.

---
 rtl/fifo_rptr_empty_if.sv | 27 ++
 rtl/fifo_rptr_empty.sv | 97 +++++++++
 tb/tb_fifo_rptr_empty.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rptr_empty_if.sv
// Read-side port bundle of the async FIFO: pop request, status outputs and the
// Gray pointers exchanged with the write domain.
interface fifo_rptr_empty_if #(
  parameter int ADDRSIZE = 3
);
  // rinc is a request, not a handshake: a pop happens on the rclk edge where
  // rinc=1 and rempty=0. rinc while rempty=1 is dropped and flagged as underflow.
  logic                rinc;
  logic                rclr_uflow;
  logic [ADDRSIZE:0]   wptr_gray;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr_gray;
  logic                rempty;
  logic                raempty;
  logic [ADDRSIZE:0]   rlevel;
  logic                runderflow;

  modport slave (
    input  rinc, rclr_uflow, wptr_gray,
    output raddr, rptr_gray, rempty, raempty, rlevel, runderflow
  );

  modport master (
    output rinc, rclr_uflow, wptr_gray,
    input  raddr, rptr_gray, rempty, raempty, rlevel, runderflow
  );
endinterface

// File: rtl/fifo_rptr_empty.sv
// Read-side pointer/empty controller of the async FIFO: synchronises the Gray
// write pointer, advances the read pointer and registers the read-side status.
package pkg_graybin;
  function automatic logic [31:0] b2g(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] g2b(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction
endpackage

module fifo_rptr_empty #(
  parameter int DEPTH         = 8,
  parameter int ADDRSIZE      = $clog2(DEPTH),
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 1
) (
  input logic              rclk,
  input logic              rrst_n,
  fifo_rptr_empty_if.slave rif
);
  import pkg_graybin::*;

  localparam int            PW     = ADDRSIZE + 1;
  localparam logic [PW-1:0] THRESH = PW'(AEMPTY_THRESH);

  logic [PW-1:0] sync_d [SYNC_STAGES];
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] wq;

  logic [PW-1:0] rbin_d, rbin_q;
  logic [PW-1:0] rgray_d, rgray_q;
  logic [PW-1:0] rlevel_d, rlevel_q;
  logic          rempty_d, rempty_q;
  logic          raempty_d, raempty_q;
  logic          uflow_d, uflow_q;
  logic          pop;

  // Plain flop chain: nothing combinational between stages.
  always_comb begin
    sync_d[0] = rif.wptr_gray;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign wq = sync_q[SYNC_STAGES-1];

  always_comb begin
    pop       = rif.rinc & ~rempty_q;
    rbin_d    = rbin_q + PW'(pop);
    rgray_d   = PW'(b2g(32'(rbin_d)));
    // Full-width compare: the MSB separates "empty" from "one full lap ahead".
    rempty_d  = (rgray_d == wq);
    rlevel_d  = PW'(g2b(32'(wq))) - rbin_d;
    raempty_d = (rlevel_d <= THRESH);
    // Set has priority over clear when both happen in one cycle.
    uflow_d   = (rif.rinc & rempty_q) | (uflow_q & ~rif.rclr_uflow);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      rbin_q    <= '0;
      rgray_q   <= '0;
      rlevel_q  <= '0;
      rempty_q  <= 1'b1;
      raempty_q <= 1'b1;
      uflow_q   <= 1'b0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      rbin_q    <= rbin_d;
      rgray_q   <= rgray_d;
      rlevel_q  <= rlevel_d;
      rempty_q  <= rempty_d;
      raempty_q <= raempty_d;
      uflow_q   <= uflow_d;
    end
  end

  assign rif.raddr      = rbin_q[ADDRSIZE-1:0];
  assign rif.rptr_gray  = rgray_q;
  assign rif.rempty     = rempty_q;
  assign rif.raempty    = raempty_q;
  assign rif.rlevel     = rlevel_q;
  assign rif.runderflow = uflow_q;
endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Bench for fifo_rptr_empty (DEPTH=8): directed test-plan cases plus a
// cycle-level reference model feeding an expected-status queue.
module tb_fifo_rptr_empty;
  localparam int ADDRSIZE = 3;
  localparam int PW       = ADDRSIZE + 1;
  localparam int W        = 14;

  logic rclk;
  logic rrst_n;

  fifo_rptr_empty_if #(.ADDRSIZE(ADDRSIZE)) rif ();

  fifo_rptr_empty #(
    .DEPTH(8), .SYNC_STAGES(2), .AEMPTY_THRESH(1)
  ) dut (
    .rclk  (rclk),
    .rrst_n(rrst_n),
    .rif   (rif)
  );

  // ---------------- clock / reset ----------------
  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish (got running, expected done)");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // reference model: binary pointers, two-stage write-pointer delay line
  int  m_rb, m_s0, m_s1, m_level;
  bit  m_empty, m_aempty, m_uf;

  function automatic logic [PW-1:0] to_gray(input int b);
    logic [PW-1:0] v;
    v = PW'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_rb = 0; m_s0 = 0; m_s1 = 0; m_level = 0;
    m_empty = 1; m_aempty = 1; m_uf = 0;
  endtask

  task automatic model_edge(input bit inc, input bit clr, input int wb);
    int  nxt;
    bit  pop;
    pop      = inc && !m_empty;
    nxt      = (m_rb + int'(pop)) & 15;
    m_uf     = (inc && m_empty) || (m_uf && !clr);
    m_empty  = (nxt == m_s1);
    m_level  = (m_s1 - nxt) & 15;
    m_aempty = (m_level <= 1);
    m_rb     = nxt;
    m_s1     = m_s0;
    m_s0     = wb & 15;
  endtask

  function automatic logic [W-1:0] pack_model();
    return {3'(m_rb & 7), to_gray(m_rb), m_empty, m_aempty, 4'(m_level), m_uf};
  endfunction

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_rempty"},  32'(rif.rempty), 1);
    check_eq({tag, "_raempty"}, 32'(rif.raempty), 1);
    check_eq({tag, "_raddr"},   32'(rif.raddr), 0);
    check_eq({tag, "_rgray"},   32'(rif.rptr_gray), 0);
    check_eq({tag, "_rlevel"},  32'(rif.rlevel), 0);
    check_eq({tag, "_uflow"},   32'(rif.runderflow), 0);
  endtask

  // ---------------- driver ----------------
  // One rclk cycle: drive inputs, predict, wait past the edge, compare.
  task automatic step(input bit inc, input bit clr, input int wb);
    logic [W-1:0] e;
    rif.rinc       = inc;
    rif.rclr_uflow = clr;
    rif.wptr_gray  = to_gray(wb);
    model_edge(inc, clr, wb);
    exp_q.push_back(pack_model());
    @(posedge rclk);
    #1;
    e = exp_q.pop_front();
    check_eq("sb_raddr",  32'(rif.raddr),      32'(e[13:11]));
    check_eq("sb_rgray",  32'(rif.rptr_gray),  32'(e[10:7]));
    check_eq("sb_rempty", 32'(rif.rempty),     32'(e[6]));
    check_eq("sb_raempt", 32'(rif.raempty),    32'(e[5]));
    check_eq("sb_rlevel", 32'(rif.rlevel),     32'(e[4:1]));
    check_eq("sb_uflow",  32'(rif.runderflow), 32'(e[0]));
  endtask

  // Reset pulse placed between edges; outputs must clear before the next edge.
  task automatic mid_reset(input string tag);
    #2 rrst_n = 1'b0;
    #1 check_reset_vals(tag);
    model_reset();
    #2 rrst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    rrst_n = 1'b0;
    rif.rinc = 1'b0;
    rif.rclr_uflow = 1'b0;
    rif.wptr_gray = '0;
    model_reset();

    // 1: reset held while rinc toggles
    for (int i = 0; i < 4; i++) begin
      @(posedge rclk); #1;
      rif.rinc = ~rif.rinc;
      check_reset_vals("rst_hold");
    end
    rif.rinc = 1'b0;
    @(negedge rclk);
    rrst_n = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);

    // 2: write pointer 3 reaches status after exactly three edges
    step(0, 0, 3); check_eq("lat_e1_rempty", 32'(rif.rempty), 1);
    step(0, 0, 3); check_eq("lat_e2_rempty", 32'(rif.rempty), 1);
    step(0, 0, 3);
    check_eq("lat_e3_rempty",  32'(rif.rempty), 0);
    check_eq("lat_e3_rlevel",  32'(rif.rlevel), 3);
    check_eq("lat_e3_raempty", 32'(rif.raempty), 0);

    // 3: three pops drain it
    step(1, 0, 3);
    check_eq("pop1_raddr", 32'(rif.raddr), 1);
    check_eq("pop1_gray",  32'(rif.rptr_gray), 32'h1);
    check_eq("pop1_level", 32'(rif.rlevel), 2);
    step(1, 0, 3);
    check_eq("pop2_gray",    32'(rif.rptr_gray), 32'h3);
    check_eq("pop2_raempty", 32'(rif.raempty), 1);
    step(1, 0, 3);
    check_eq("pop3_raddr",  32'(rif.raddr), 3);
    check_eq("pop3_gray",   32'(rif.rptr_gray), 32'h2);
    check_eq("pop3_rempty", 32'(rif.rempty), 1);
    check_eq("pop3_level",  32'(rif.rlevel), 0);

    // 4: underflow set / clear / set-wins
    step(1, 0, 3);
    check_eq("uf_set",   32'(rif.runderflow), 1);
    check_eq("uf_raddr", 32'(rif.raddr), 3);
    check_eq("uf_gray",  32'(rif.rptr_gray), 32'h2);
    step(0, 1, 3);
    check_eq("uf_clr", 32'(rif.runderflow), 0);
    step(1, 1, 3);
    check_eq("uf_setwins", 32'(rif.runderflow), 1);
    step(0, 1, 3);

    // 5: full lap and wrap
    mid_reset("rst_lap");
    for (int i = 0; i < 3; i++) step(0, 0, 8);
    check_eq("lap_rempty", 32'(rif.rempty), 0);
    check_eq("lap_rlevel", 32'(rif.rlevel), 8);
    for (int i = 0; i < 7; i++) step(1, 0, 8);
    check_eq("wrap_raddr7", 32'(rif.raddr), 7);
    check_eq("wrap_gray7",  32'(rif.rptr_gray), 32'h4);
    step(1, 0, 8);
    check_eq("wrap_raddr0",  32'(rif.raddr), 0);
    check_eq("wrap_gray8",   32'(rif.rptr_gray), 32'hc);
    check_eq("wrap_rempty",  32'(rif.rempty), 1);
    for (int i = 0; i < 3; i++) step(0, 0, 9);
    check_eq("lap9_rlevel", 32'(rif.rlevel), 1);
    check_eq("lap9_rempty", 32'(rif.rempty), 0);

    // 6: reset mid-stream at level 5, then pop gated by resynchronisation
    for (int i = 0; i < 3; i++) step(0, 0, 13);
    check_eq("pre_rst_level", 32'(rif.rlevel), 5);
    mid_reset("rst_mid");
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    check_eq("post_rst_raddr", 32'(rif.raddr), 0);
    for (int i = 0; i < 3; i++) step(1, 1, 1);
    check_eq("resync_blocked", 32'(rif.raddr), 0);
    step(1, 0, 1);
    check_eq("resync_pop", 32'(rif.raddr), 1);

    // random traffic: writer never runs more than DEPTH ahead of the reader
    w = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1 && ((w - m_rb) & 15) < 8) w = (w + 1) & 15;
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), w);
    end

    check_eq("exp_q_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
